// File: rtl/ib_mul_sched.sv
// Round-robin scheduler that shares one 4-cycle 8x8 multiplier between N_REQ requesters.
// Operands are latched on grant and held until the multiplier returns its product.
`timescale 1ns/1ps
module ib_mul_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic [8*N_REQ-1:0]   i_req_a,
    input  logic [8*N_REQ-1:0]   i_req_b,
    output logic                 o_mul_start,
    output logic [7:0]           o_mul_a,
    output logic [7:0]           o_mul_b,
    input  logic [15:0]          i_mul_c,
    input  logic                 i_mul_done,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [15:0]          o_res_c,
    output logic [ID_W-1:0]      o_res_id,
    output logic                 o_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;
    logic [15:0]     res_c_q, res_c_d;
    logic            res_valid_q, res_valid_d;
    logic            err_q, err_d;
    logic [2:0]      wd_q, wd_d;

    logic [7:0]      req_a_arr [N_REQ];
    logic [7:0]      req_b_arr [N_REQ];
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [ID_W:0]   cand;
    logic            slot_free;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_a_arr[gi] = i_req_a[8*gi +: 8];
            assign req_b_arr[gi] = i_req_b[8*gi +: 8];
        end
    endgenerate

    // Scan from the slot after the last winner so the previous winner is checked last.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!win_found && i_req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    assign slot_free = !res_valid_q || i_res_ready;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gid_d       = gid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_c_d     = res_c_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        wd_d        = wd_q;
        o_req_ready = '0;

        if (res_valid_q && i_res_ready) begin
            res_valid_d = 1'b0;
        end
        if (i_mul_done && state_q != S_WAIT) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found && slot_free) begin
                    o_req_ready[win_id] = 1'b1;
                    mul_a_d = req_a_arr[win_id];
                    mul_b_d = req_b_arr[win_id];
                    gid_d   = win_id;
                    rr_d    = win_id;
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_mul_done) begin
                    res_c_d     = i_mul_c;
                    res_id_d    = gid_q;
                    res_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (wd_q == 3'd7) begin
                    // Eighth silent WAIT cycle: abandon the operation.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            rr_q        <= ID_W'(N_REQ - 1);
            gid_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_c_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gid_q       <= gid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_c_q     <= res_c_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign o_mul_start = (state_q == S_START);
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;
    assign o_res_valid = res_valid_q;
    assign o_res_c     = res_c_q;
    assign o_res_id    = res_id_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ib_mul_sched.sv
// Directed bench for ib_mul_sched with a behavioural 4-cycle multiplier.
`timescale 1ns/1ps
module tb_ib_mul_sched;

    logic        clk;
    logic        nrst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_c;
    logic        mul_done;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_c;
    logic [1:0]  res_id;
    logic        err;

    logic        mul_en;
    logic        inj_done;
    logic [2:0]  mcnt;
    logic [7:0]  ma;
    logic [7:0]  mb;

    int n_checks = 0;
    int n_errors = 0;

    ib_mul_sched #(.N_REQ(4), .ID_W(2)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_mul_start (mul_start),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_c     (mul_c),
        .i_mul_done  (mul_done),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_c     (res_c),
        .o_res_id    (res_id),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: operands sampled with start, done pulse four cycles after start.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mcnt <= 3'd0;
            ma   <= 8'd0;
            mb   <= 8'd0;
        end else if (mul_start) begin
            mcnt <= 3'd4;
            ma   <= mul_a;
            mb   <= mul_b;
        end else if (mcnt != 3'd0) begin
            mcnt <= mcnt - 3'd1;
        end
    end
    assign mul_done = ((mcnt == 3'd1) && mul_en) || inj_done;
    assign mul_c    = {8'd0, ma} * {8'd0, mb};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_c   [5] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10};

    initial begin
        nrst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        res_ready = 1'b1; mul_en = 1'b1; inj_done = 1'b0;
        cyc(2);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        chk("rst_res", {15'd0, res_valid, res_c}, 32'd0);
        chk("rst_id_err", {29'd0, res_id, err}, 32'd0);
        nrst = 1'b1;
        cyc(1);

        // Single request from requester 1
        req_valid = 4'b0010; req_a = 32'h0000FF00; req_b = 32'h0000FF00;
        #1 chk("t1_ready", 32'(req_ready), 32'b0010);
        cyc(1); req_valid = 4'b0000;
        #1 chk("t1_start", 32'(mul_start), 32'd1);
        chk("t1_ready_start", 32'(req_ready), 32'd0);
        cyc(1); chk("t1_start_off", 32'(mul_start), 32'd0);
        cyc(3); chk("t1_not_yet", 32'(res_valid), 32'd0);
        cyc(1); chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_c", 32'(res_c), 32'hFE01);
        chk("t1_id", 32'(res_id), 32'd1);
        cyc(1); chk("t1_drained", 32'(res_valid), 32'd0);

        // Round robin from a fresh reset
        nrst = 1'b0; cyc(1); nrst = 1'b1; cyc(1);
        req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {4{8'd10}}; req_valid = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("rr_grant", 32'(req_ready), 32'(exp_rdy[n]));
            cyc(1);
            if (n == 4) req_valid = 4'b0000;
            cyc(5);
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_c", 32'(res_c), 32'(exp_c[n]));
            chk("rr_id", 32'(res_id), 32'(exp_id[n]));
        end
        cyc(1); chk("rr_drained", 32'(res_valid), 32'd0);

        // Backpressure: result held, req2 waits until the drain cycle
        res_ready = 1'b0;
        req_a = {8'd0, 8'd7, 8'd0, 8'd13}; req_b = {8'd0, 8'd9, 8'd0, 8'd11};
        req_valid = 4'b0001;
        #1 chk("bp_grant0", 32'(req_ready), 32'b0001);
        cyc(1); req_valid = 4'b0100;
        cyc(5);
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {9'd0, res_valid, res_id, res_c, req_ready}, {9'd0, 1'b1, 2'd0, 16'h008F, 4'b0000});
            cyc(1);
        end
        res_ready = 1'b1;
        #1 chk("bp_grant2", 32'(req_ready), 32'b0100);
        chk("bp_drain_valid", 32'(res_valid), 32'd1);
        cyc(1); req_valid = 4'b0000;
        chk("bp_drained", 32'(res_valid), 32'd0);
        cyc(5);
        chk("bp_res", {13'd0, res_valid, res_id, res_c}, {13'd0, 1'b1, 2'd2, 16'h003F});
        cyc(1);

        // Operand stability while requester inputs churn
        req_a = 32'h12000000; req_b = 32'h34000000; req_valid = 4'b1000;
        #1 chk("stab_grant", 32'(req_ready), 32'b1000);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            req_valid = 4'b0000; req_a = $urandom; req_b = $urandom;
            #1 chk("stab_ab", {16'd0, mul_a, mul_b}, 32'h00001234);
        end
        cyc(1);
        chk("stab_res", {13'd0, res_valid, res_id, res_c}, {13'd0, 1'b1, 2'd3, 16'h03A8});
        cyc(1); chk("err_clean", 32'(err), 32'd0);

        // Watchdog: multiplier never answers
        mul_en = 1'b0; req_a = 32'h02; req_b = 32'h03; req_valid = 4'b0001;
        #1 chk("wd_grant", 32'(req_ready), 32'b0001);
        cyc(5); chk("wd_ready_wait", 32'(req_ready), 32'd0);
        cyc(4); chk("wd_err_early", 32'(err), 32'd0);
        cyc(1); chk("wd_err", 32'(err), 32'd1);
        chk("wd_no_res", 32'(res_valid), 32'd0);
        chk("wd_idle_grant", 32'(req_ready), 32'b0001);
        mul_en = 1'b1;
        cyc(1); req_valid = 4'b0000;
        cyc(5);
        chk("wd_after_res", {13'd0, res_valid, res_id, res_c}, {13'd0, 1'b1, 2'd0, 16'h0006});
        chk("wd_err_sticky", 32'(err), 32'd1);

        // Done pulse while idle
        nrst = 1'b0; cyc(1);
        chk("inj_rst_err", 32'(err), 32'd0);
        nrst = 1'b1; cyc(1);
        inj_done = 1'b1; cyc(1); inj_done = 1'b0;
        chk("inj_err", 32'(err), 32'd1);
        cyc(3); chk("inj_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of an operation
        nrst = 1'b0; cyc(1); nrst = 1'b1; cyc(1);
        req_a = 32'h00550000; req_b = 32'h00AA0000; req_valid = 4'b0100;
        #1 chk("mr_grant", 32'(req_ready), 32'b0100);
        cyc(1); req_valid = 4'b0000;
        #1 chk("mr_start", {23'd0, mul_start, mul_a}, {23'd0, 1'b1, 8'h55});
        nrst = 1'b0;
        #1 chk("mr_start_drop", 32'(mul_start), 32'd0);
        chk("mr_ab", {16'd0, mul_a, mul_b}, 32'd0);
        chk("mr_res", {12'd0, res_valid, err, res_id, res_c}, 32'd0);
        cyc(2); nrst = 1'b1;
        req_valid = 4'hF;
        #1 chk("mr_first_grant", 32'(req_ready), 32'b0001);
        cyc(1); req_valid = 4'b0000;
        cyc(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
